// File: rtl/ins_pkg.sv
// Shared instruction-format constants and loader state encoding.
// Used by the field encoder, the program loader and the instruction decoder.
package ins_pkg;

  localparam int OP_W  = 6;
  localparam int REG_W = 5;
  localparam int IMM_W = 16;
  localparam int INS_W = 32;

  // Field LSB positions inside the 32-bit instruction word
  localparam int OP_LSB  = 26;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ld_state_e;

endpackage

// File: rtl/ins_field_encoder.sv
// Combinational packer: decoded fields plus itype in, 32-bit instruction word out.
// R-type places rd at [15:11] with [10:0] zero; I-type places imm at [15:0].
module ins_field_encoder
  import ins_pkg::*;
(
  input  logic [OP_W-1:0]  opcode,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic [REG_W-1:0] rd,
  input  logic [IMM_W-1:0] imm,
  input  logic             itype,
  output logic [INS_W-1:0] word
);

  // Assemble the word from its fields; the unused field never reaches the output
  always_comb begin
    word = '0;
    word[OP_LSB +: OP_W] = opcode;
    word[RS_LSB +: REG_W] = rs;
    word[RT_LSB +: REG_W] = rt;
    if (itype) begin
      word[IMM_LSB +: IMM_W] = imm;
    end else begin
      word[RD_LSB +: REG_W] = rd;
    end
  end

endmodule

// File: rtl/ins_encode_loader.sv
// Instruction encoder and program loader: accepts field sets over valid/ready,
// packs them into instruction words and writes them to consecutive addresses.
// Optional build macro: LOADER_CHECKSUM_EN (running XOR of written words).
module ins_encode_loader
  import ins_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   opcode,
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  input  logic [REG_W-1:0]  rd,
  input  logic [IMM_W-1:0]  imm,
  input  logic              itype,
  input  logic              last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [INS_W-1:0]  mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              done,
  output logic [INS_W-1:0]  checksum
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [INS_W-1:0]  wdata_q, wdata_d;
  logic              done_q, done_d;
  logic [INS_W-1:0]  word;
  logic              accept;
  logic              start_ok;

  ins_field_encoder u_enc (
    .opcode (opcode),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .imm    (imm),
    .itype  (itype),
    .word   (word)
  );

  assign in_ready = (state_q == LOAD);
  assign accept   = in_valid && in_ready;
  assign start_ok = start && (state_q == IDLE);

  // Session sequencing, address/count bookkeeping and write-port staging
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    full_d  = full_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          addr_d  = BASE;
          count_d = '0;
          full_d  = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = word;
          addr_d  = addr_q + 1'b1;
          count_d = count_q + 1'b1;
          // The top address ends the session; the pointer is reloaded on start, so it never wraps into use
          if (addr_q == LAST_ADDR) begin
            full_d = 1'b1;
          end
          if (last || (addr_q == LAST_ADDR)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      full_q  <= full_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = waddr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign full      = full_q;
  assign done      = done_q;

`ifdef LOADER_CHECKSUM_EN
  logic [INS_W-1:0] csum_q, csum_d;

  // Running XOR over the session's written words, cleared when a session starts
  always_comb begin
    csum_d = csum_q;
    if (start_ok) begin
      csum_d = '0;
    end else if (accept) begin
      csum_d = csum_q ^ word;
    end
  end

  // Checksum register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign checksum        = '0;
`endif

endmodule

// File: tb/tb_ins_encode_loader.sv
// Scoreboard bench for ins_encode_loader: driver pushes expected writes and
// session results into queues; a monitor pops and compares as the DUT writes.
module tb_ins_encode_loader;

  localparam int AW   = 3;
  localparam int BASE = 4;
  localparam int CAP  = (1 << AW) - BASE;   // words that fit before the top address

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic        it;
  } fld_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wexp_t;

  typedef struct {
    logic [AW:0]  cnt;
    logic         full;
    logic [31:0]  cs;
  } dexp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [5:0]    opcode = '0;
  logic [4:0]    rs = '0;
  logic [4:0]    rt = '0;
  logic [4:0]    rd = '0;
  logic [15:0]   imm = '0;
  logic          itype = 1'b0;
  logic          last = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
  logic          full;
  logic          done;
  logic [31:0]   checksum;

  int checks = 0;
  int errors = 0;

  fld_t        stim_q[$];
  logic [31:0] word_q[$];
  wexp_t       wr_q[$];
  dexp_t       dn_q[$];

  ins_encode_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .itype(itype), .last(last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count),
    .full(full), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference instruction format
  function automatic logic [31:0] encode(input fld_t f);
    if (f.it) return {f.op, f.rs, f.rt, f.imm};
    return {f.op, f.rs, f.rt, f.rd, 11'b0};
  endfunction

  function automatic fld_t rand_fld();
    fld_t f;
    f.op  = 6'($urandom);
    f.rs  = 5'($urandom);
    f.rt  = 5'($urandom);
    f.rd  = 5'($urandom);
    f.imm = 16'($urandom);
    f.it  = 1'($urandom);
    return f;
  endfunction

  // Monitor: compares each presented write and session end against the queues
  always begin
    @(posedge clk);
    #1;
    if (!rst) begin
      if (mem_we) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_write", {32'(mem_addr), mem_wdata}, 64'h0);
        end else begin
          wexp_t e;
          e = wr_q.pop_front();
          chk("mem_addr", 64'(mem_addr), 64'(e.addr));
          chk("mem_wdata", 64'(mem_wdata), 64'(e.data));
        end
      end
      if (done) begin
        chk("done_with_final_we", 64'(mem_we), 64'h1);
        if (dn_q.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'h0);
        end else begin
          dexp_t d;
          d = dn_q.pop_front();
          chk("count_at_done", 64'(count), 64'(d.cnt));
          chk("full_at_done", 64'(full), 64'(d.full));
          chk("checksum_at_done", 64'(checksum), 64'(d.cs));
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("in_ready_after_start", 64'(in_ready), 64'h1);
  endtask

  task automatic present(input fld_t f, input bit is_last);
    opcode = f.op; rs = f.rs; rt = f.rt; rd = f.rd; imm = f.imm; itype = f.it;
    last = is_last;
    in_valid = 1'b1;
  endtask

  // One session over stim_q/word_q. Expected results come from the loader's
  // rules: consecutive addresses from BASE, stop at last or at the top address.
  task automatic run_session(input bit use_last, input int gap_at1, input int stall_max);
    int n, acc;
    bit fexp;
    logic [31:0] cs;
    n    = stim_q.size();
    acc  = (n < CAP) ? n : CAP;
    fexp = (n >= CAP);
    cs   = '0;
    pulse_start();
    for (int i = 0; i < acc; i++) begin
      int gap;
      gap = (i == 1) ? gap_at1 : int'($urandom_range(0, stall_max));
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      chk("in_ready_in_load", 64'(in_ready), 64'h1);
      present(stim_q[i], use_last && (i == n - 1));
      wr_q.push_back('{addr: AW'(BASE + i), data: word_q[i]});
      cs ^= word_q[i];
      if (i == acc - 1) begin
`ifdef LOADER_CHECKSUM_EN
        dn_q.push_back('{cnt: (AW+1)'(acc), full: fexp, cs: cs});
`else
        dn_q.push_back('{cnt: (AW+1)'(acc), full: fexp, cs: 32'h0});
`endif
      end
      @(negedge clk);
    end
    chk("in_ready_after_end", 64'(in_ready), 64'h0);
    for (int i = acc; i < n; i++) begin
      present(stim_q[i], use_last && (i == n - 1));
      @(negedge clk);
      chk("in_ready_refuses_extra", 64'(in_ready), 64'h0);
    end
    in_valid = 1'b0;
    last = 1'b0;
    repeat (3) @(negedge clk);
    chk("count_holds_idle", 64'(count), 64'(acc));
    chk("full_holds_idle", 64'(full), 64'(fexp));
    chk("in_ready_idle", 64'(in_ready), 64'h0);
    stim_q.delete();
    word_q.delete();
  endtask

  task automatic add_word(input fld_t f);
    stim_q.push_back(f);
    word_q.push_back(encode(f));
  endtask

  initial begin
    fld_t f;
    // Reset from time zero, release away from the edge
    repeat (2) @(negedge clk);
    chk("reset_mem_we", 64'(mem_we), 64'h0);
    chk("reset_count", 64'(count), 64'h0);
    chk("reset_checksum", 64'(checksum), 64'h0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_ready_before_start", 64'(in_ready), 64'h0);
    end

    // R-type single word with a known encoding
    f = '{op: 6'h00, rs: 5'd1, rt: 5'd2, rd: 5'd3, imm: 16'hFFFF, it: 1'b0};
    stim_q.push_back(f);
    word_q.push_back(32'h0022_1800);
    run_session(1'b1, 0, 0);

    // I-type stream back-to-back, first word known
    f = '{op: 6'h23, rs: 5'd5, rt: 5'd6, rd: 5'h1F, imm: 16'hABCD, it: 1'b1};
    stim_q.push_back(f);
    word_q.push_back(32'h8CA6_ABCD);
    f.imm = 16'h0001; f.rt = 5'd7; add_word(f);
    f.imm = 16'h8000; f.rs = 5'd31; add_word(f);
    run_session(1'b1, 0, 0);

    // Three-cycle stall mid-stream
    for (int i = 0; i < 3; i++) add_word(rand_fld());
    run_session(1'b1, 3, 0);

    // Full: more words than addresses, no last
    for (int i = 0; i < CAP + 2; i++) add_word(rand_fld());
    run_session(1'b0, 0, 0);

    // Last coincides with the top address
    for (int i = 0; i < CAP; i++) add_word(rand_fld());
    run_session(1'b1, 0, 1);

    // Reset mid-session after two writes
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      f = rand_fld();
      present(f, 1'b0);
      wr_q.push_back('{addr: AW'(BASE + i), data: encode(f)});
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_mem_we", 64'(mem_we), 64'h0);
    chk("async_rst_addr", 64'(mem_addr), 64'h0);
    chk("async_rst_wdata", 64'(mem_wdata), 64'h0);
    chk("async_rst_count", 64'(count), 64'h0);
    chk("async_rst_full", 64'(full), 64'h0);
    chk("async_rst_done", 64'(done), 64'h0);
    chk("async_rst_checksum", 64'(checksum), 64'h0);
    chk("async_rst_ready", 64'(in_ready), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(in_ready), 64'h0);
    for (int i = 0; i < 2; i++) add_word(rand_fld());
    run_session(1'b1, 0, 1);

    // Randomized sessions
    for (int s = 0; s < 10; s++) begin
      int n;
      n = int'($urandom_range(1, CAP + 2));
      for (int i = 0; i < n; i++) add_word(rand_fld());
      run_session(1'b1, int'($urandom_range(0, 2)), 2);
    end

    repeat (3) @(negedge clk);
    chk("writes_outstanding", 64'(wr_q.size()), 64'h0);
    chk("dones_outstanding", 64'(dn_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ins_encode_loader.md
# ins_encode_loader

Instruction encoder and program loader for the multicycle CPU. It accepts decoded instruction fields (opcode, Rs, Rt, Rd or immediate) over a valid/ready handshake and packs each one into the 32-bit instruction word that the instruction decoder unpacks. It writes the words into instruction memory at consecutive addresses. It sits between the bench or boot source and the instruction memory, and is the write-side counterpart of the IR/decoder path.

## Interface
Parameters:
- ADDR_W, 8, instruction memory word-address width
- BASE_ADDR, 0, first address written after start

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load session (honoured only in IDLE)
- in_valid  in  1  field set on the field inputs is valid
- in_ready  out  1  loader accepts a field set this cycle
- opcode  in  6  instruction bits [31:26]
- rs  in  5  bits [25:21]
- rt  in  5  bits [20:16]
- rd  in  5  bits [15:11], R-type only
- imm  in  16  bits [15:0], I-type only
- itype  in  1  1 = I-type (use imm), 0 = R-type (use rd)
- last  in  1  this field set is the final instruction of the session
- mem_we  out  1  instruction memory write strobe
- mem_addr  out  ADDR_W  write word address
- mem_wdata  out  32  encoded instruction word
- count  out  ADDR_W+1  words written in the current or most recent session
- full  out  1  session stopped because the last address was written
- done  out  1  one-cycle pulse at the end of a session
- checksum  out  32  running XOR of written words (see Configuration)

## Operation
- FSM states are IDLE, LOAD and DONE.
- IDLE: in_ready=0. On start, set the next address to BASE_ADDR, clear count and full, and go to LOAD.
- LOAD: in_ready=1. A transfer is accepted when in_valid and in_ready are both high on a rising edge.
- Encoding:
  - R-type: {opcode, rs, rt, rd, 11'b0}
  - I-type: {opcode, rs, rt, imm}
  - The unused field is ignored.
- On each accepted transfer:
  - Register mem_wdata, mem_addr (current next address) and mem_we=1.
  - Increment the next address and count.
- Exit from LOAD to DONE:
  - If last=1 on the accepted transfer, go to DONE.
  - If the accepted transfer's address is 2^ADDR_W−1, set full=1 and go to DONE. The address never wraps.
  - If both conditions hold, full=1 and the session exits once.
- DONE: done=1 for one cycle, then return to IDLE. in_ready=0.
- start asserted outside IDLE is ignored.
- count and full hold their values in IDLE until the next start.
- Reset mid-session: return to IDLE immediately. Words already written stay in memory; no partial word is written.

## Timing
- All outputs are registered, except in_ready, which is decoded from the state register.
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0, done=0, checksum=0. State is IDLE.
- start at edge k gives in_ready=1 in cycle k+1.
- An accept at edge k gives mem_we=1 with address and data in cycle k+1. mem_we lasts one cycle per accept.
- Back-to-back accepts give one word per cycle.
- An accept with last (or at full) at edge k gives in_ready=0 and done=1 in cycle k+1, the same cycle as the final mem_we. The FSM is in IDLE in cycle k+2.
- Start-to-first-write latency is 2 cycles minimum.

## Configuration
- LOADER_CHECKSUM_EN defined: checksum is cleared on start and XOR-accumulates every word written. Its value is final in the done cycle and holds until the next start.
- LOADER_CHECKSUM_EN undefined: no accumulator logic is built and checksum is tied to 0.

## Structure
- Package ins_pkg holds:
  - field widths: OP_W=6, REG_W=5, IMM_W=16
  - bit positions of each field
  - the loader state enum (IDLE, LOAD, DONE)
- The decoder uses the same constants.
- Sub-module ins_field_encoder is purely combinational: fields plus itype in, 32-bit word out. The loader registers its output.

## Test plan
- Reset: rst=1 asynchronously mid-cycle → all outputs 0 at once. After release, in_ready=0 and no write until start.
- R-type: start, then opcode=0, rs=1, rt=2, rd=3, itype=0, last=1 → one write, mem_addr=0, mem_wdata=32'h00221800, done next to the write, count=1.
- I-type stream: BASE_ADDR=4, send 3 words back-to-back: {6'h23,rs=5,rt=6,imm=16'hABCD}, then two more, last on the third → writes at addresses 4, 5, 6 on consecutive cycles. First word = 32'h8CA6ABCD. count=3.
- Stall: in_valid low for 3 cycles mid-stream → no mem_we during the gap; addresses stay contiguous.
- Full: ADDR_W=2, BASE_ADDR=0, stream 6 words with no last → 4 writes (addresses 0–3), full=1, done pulses, in_ready drops. Words 5–6 are not accepted.
- Reset during LOAD after 2 writes: → IDLE, count=0. A new start restarts at BASE_ADDR. With LOADER_CHECKSUM_EN, checksum equals the XOR of only the new session's words.
